// File: rtl/regfile_sequencer.sv
// regfile_sequencer: drives a strobed register file through a fixed
// select / read A / read B / capture B / write-back sequence for one ALU op.
// Optional build macro RFSEQ_FLAGS_EN adds registered zero/carry flags.
module regfile_sequencer #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [2:0]        i_req_op,
    input  logic [3:0]        i_req_rd,
    input  logic [3:0]        i_req_rs1,
    input  logic [3:0]        i_req_rs2,
    output logic              o_selectLatch,
    output logic              o_outputA,
    output logic              o_outputB,
    output logic              o_latchC,
    output logic [DATA_W-1:0] o_bus_data,
    output logic              o_bus_valid,
    input  logic [DATA_W-1:0] i_rf_data,
    output logic [DATA_W-1:0] o_result,
    output logic              o_done,
`ifdef RFSEQ_FLAGS_EN
    output logic              o_flag_z,
    output logic              o_flag_c,
`endif
    output logic              o_busy
);

    typedef enum logic [2:0] {StIdle, StSel, StRdA, StRdB, StCapB, StWb} state_t;

    localparam logic [2:0] OpAdd = 3'd0;
    localparam logic [2:0] OpSub = 3'd1;
    localparam logic [2:0] OpAnd = 3'd2;
    localparam logic [2:0] OpOr  = 3'd3;
    localparam logic [2:0] OpXor = 3'd4;
    localparam logic [2:0] OpPass = 3'd5;
    localparam logic [2:0] OpShl = 3'd6;
    localparam logic [2:0] OpShr = 3'd7;

    state_t            stateQ, stateD;
    logic [2:0]        opQ;
    logic [3:0]        rdQ, rs1Q, rs2Q;
    logic [DATA_W-1:0] opAQ, opBQ;
    logic [DATA_W-1:0] aluRes;
    logic              accept;

    assign accept = (stateQ == StIdle) && i_req_valid;

    // ALU on the captured operands; only consumed during write-back
    always_comb begin
        aluRes = '0;
        case (opQ)
            OpAdd:   aluRes = opAQ + opBQ;
            OpSub:   aluRes = opAQ - opBQ;
            OpAnd:   aluRes = opAQ & opBQ;
            OpOr:    aluRes = opAQ | opBQ;
            OpXor:   aluRes = opAQ ^ opBQ;
            OpPass:  aluRes = opAQ;
            OpShl:   aluRes = {opAQ[DATA_W-2:0], 1'b0};
            OpShr:   aluRes = {1'b0, opAQ[DATA_W-1:1]};
            default: aluRes = '0;
        endcase
    end

    // Next state and per-state strobes; bus is zero outside SEL and WB
    always_comb begin
        stateD        = stateQ;
        o_req_ready   = 1'b0;
        o_selectLatch = 1'b0;
        o_outputA     = 1'b0;
        o_outputB     = 1'b0;
        o_latchC      = 1'b0;
        o_bus_valid   = 1'b0;
        o_bus_data    = '0;
        unique case (stateQ)
            StIdle: begin
                o_req_ready = 1'b1;
                if (i_req_valid) stateD = StSel;
            end
            StSel: begin
                o_selectLatch = 1'b1;
                o_bus_valid   = 1'b1;
                o_bus_data    = DATA_W'({rdQ, rs2Q, rs1Q});
                stateD        = StRdA;
            end
            StRdA: begin
                o_outputA = 1'b1;
                stateD    = StRdB;
            end
            StRdB: begin
                o_outputB = 1'b1;
                stateD    = StCapB;
            end
            StCapB: stateD = StWb;
            StWb: begin
                o_latchC    = 1'b1;
                o_bus_valid = 1'b1;
                o_bus_data  = aluRes;
                stateD      = StIdle;
            end
            default: stateD = StIdle;
        endcase
    end

    assign o_busy = (stateQ != StIdle);

    // State, captured request fields, operands, result and done pulse
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            stateQ   <= StIdle;
            opQ      <= '0;
            rdQ      <= '0;
            rs1Q     <= '0;
            rs2Q     <= '0;
            opAQ     <= '0;
            opBQ     <= '0;
            o_result <= '0;
            o_done   <= 1'b0;
        end else begin
            stateQ <= stateD;
            o_done <= (stateQ == StWb);
            if (accept) begin
                opQ  <= i_req_op;
                rdQ  <= i_req_rd;
                rs1Q <= i_req_rs1;
                rs2Q <= i_req_rs2;
            end
            // Register file read data lags its output strobe by one cycle
            if (stateQ == StRdB)  opAQ <= i_rf_data;
            if (stateQ == StCapB) opBQ <= i_rf_data;
            if (stateQ == StWb)   o_result <= aluRes;
        end
    end

`ifdef RFSEQ_FLAGS_EN
    logic aluCarry;

    // Carry/borrow/shifted-out bit of the current op
    always_comb begin
        aluCarry = 1'b0;
        case (opQ)
            OpAdd:   aluCarry = (opAQ + opBQ) < opAQ;
            OpSub:   aluCarry = opAQ < opBQ;
            OpShl:   aluCarry = opAQ[DATA_W-1];
            OpShr:   aluCarry = opAQ[0];
            default: aluCarry = 1'b0;
        endcase
    end

    // Flags update only on write-back and hold otherwise
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_flag_z <= 1'b0;
            o_flag_c <= 1'b0;
        end else if (stateQ == StWb) begin
            o_flag_z <= (aluRes == '0);
            o_flag_c <= aluCarry;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: behavioural register file, reference ALU and
// a scoreboard of expected select words / write-back values.
module tb_regfile_sequencer;

    logic        i_Clk = 1'b0;
    logic        i_Reset;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [2:0]  i_req_op;
    logic [3:0]  i_req_rd, i_req_rs1, i_req_rs2;
    logic        o_selectLatch, o_outputA, o_outputB, o_latchC;
    logic [15:0] o_bus_data;
    logic        o_bus_valid;
    logic [15:0] i_rf_data;
    logic [15:0] o_result;
    logic        o_done, o_busy;
`ifdef RFSEQ_FLAGS_EN
    logic        o_flag_z, o_flag_c;
`endif

    regfile_sequencer #(.DATA_W(16)) dut (
        .i_Clk(i_Clk), .i_Reset(i_Reset),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_op(i_req_op), .i_req_rd(i_req_rd), .i_req_rs1(i_req_rs1),
        .i_req_rs2(i_req_rs2),
        .o_selectLatch(o_selectLatch), .o_outputA(o_outputA), .o_outputB(o_outputB),
        .o_latchC(o_latchC), .o_bus_data(o_bus_data), .o_bus_valid(o_bus_valid),
        .i_rf_data(i_rf_data), .o_result(o_result), .o_done(o_done),
`ifdef RFSEQ_FLAGS_EN
        .o_flag_z(o_flag_z), .o_flag_c(o_flag_c),
`endif
        .o_busy(o_busy)
    );

    always #5 i_Clk = ~i_Clk;

    // Behavioural register file: r0 reads zero and ignores writes
    logic [15:0] regs [16];
    logic [3:0]  selRd, selRs1, selRs2;
    logic        tbLoad = 1'b0;
    logic [3:0]  tbIdx = '0;
    logic [15:0] tbVal = '0;

    initial for (int i = 0; i < 16; i++) regs[i] = '0;

    always @(posedge i_Clk) begin
        if (tbLoad && tbIdx != 0) regs[tbIdx] <= tbVal;
        if (o_selectLatch) {selRd, selRs2, selRs1} <= o_bus_data[11:0];
        if (o_outputA) i_rf_data <= (selRs1 == 0) ? 16'h0 : regs[selRs1];
        if (o_outputB) i_rf_data <= (selRs2 == 0) ? 16'h0 : regs[selRs2];
        if (o_latchC && selRd != 0) regs[selRd] <= o_bus_data;
    end

    typedef struct {
        logic [15:0] sel;
        logic [15:0] res;
        logic        z;
        logic        c;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    int   doneCount = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, expv, cycle);
        end
    endtask

    task automatic timeoutFail(input string tag);
        checks++;
        errors++;
        $error("FAIL %s observed=timeout expected=event (cycle %0d)", tag, cycle);
    endtask

    function automatic logic [15:0] rdReg(input logic [3:0] idx);
        return (idx == 0) ? 16'h0 : regs[idx];
    endfunction

    task automatic refAlu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] res, output logic z, output logic c);
        logic [16:0] wide;
        c = 1'b0;
        case (op)
            3'd0: begin wide = {1'b0, a} + {1'b0, b}; res = wide[15:0]; c = wide[16]; end
            3'd1: begin res = a - b; c = (a < b); end
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: res = a ^ b;
            3'd5: res = a;
            3'd6: begin res = a << 1; c = a[15]; end
            default: begin res = a >> 1; c = a[0]; end
        endcase
        z = (res == 16'h0);
    endtask

    // One clock, then sample and run the per-cycle invariants and scoreboard
    task automatic tick();
        exp_t it;
        @(posedge i_Clk);
        #1;
        cycle++;
        chk("strobe_onehot", 32'($countones({o_selectLatch, o_outputA, o_outputB, o_latchC}) <= 1),
            32'd1);
        chk("bus_valid", 32'(o_bus_valid), 32'(o_selectLatch | o_latchC));
        chk("ready_vs_busy", 32'(o_req_ready), 32'(!o_busy));
        if (!o_bus_valid) chk("bus_zero", 32'(o_bus_data), 32'd0);
        if (sb.size() == 0) begin
            chk("latchC_unexpected", 32'(o_latchC), 32'd0);
            chk("done_unexpected", 32'(o_done), 32'd0);
        end else begin
            if (o_selectLatch) chk("sel_bus", 32'(o_bus_data), 32'(sb[0].sel));
            if (o_latchC) chk("wb_bus", 32'(o_bus_data), 32'(sb[0].res));
            if (o_done) begin
                it = sb.pop_front();
                doneCount++;
                chk("result", 32'(o_result), 32'(it.res));
                chk("latency", 32'(cycle - it.acc), 32'd6);
`ifdef RFSEQ_FLAGS_EN
                chk("flag_z", 32'(o_flag_z), 32'(it.z));
                chk("flag_c", 32'(o_flag_c), 32'(it.c));
`endif
            end
        end
    endtask

    task automatic load(input logic [3:0] idx, input logic [15:0] val);
        tbLoad = 1'b1;
        tbIdx  = idx;
        tbVal  = val;
        tick();
        tbLoad = 1'b0;
    endtask

    // Present a request, wait for ready, push the expectation, cross the accepting edge
    task automatic issue(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                         input logic [3:0] rs2, input bit keepValid, input bit expectDone);
        exp_t it;
        int   n = 0;
        i_req_op    = op;
        i_req_rd    = rd;
        i_req_rs1   = rs1;
        i_req_rs2   = rs2;
        i_req_valid = 1'b1;
        while (!o_req_ready && n < 20) begin
            tick();
            n++;
        end
        if (!o_req_ready) begin
            timeoutFail("ready_timeout");
            i_req_valid = 1'b0;
            return;
        end
        if (expectDone) chk("accept_on_done", 32'(o_done), 32'd1);
        it.sel = {4'h0, rd, rs2, rs1};
        refAlu(op, rdReg(rs1), rdReg(rs2), it.res, it.z, it.c);
        it.acc = cycle;
        sb.push_back(it);
        tick();
        if (!keepValid) i_req_valid = 1'b0;
    endtask

    task automatic waitDone();
        int d0 = doneCount;
        int n = 0;
        while (doneCount == d0 && n < 20) begin
            tick();
            n++;
        end
        if (doneCount == d0) timeoutFail("done_timeout");
    endtask

    initial begin
        logic [15:0] keep6;
        int          n;
        i_Reset     = 1'b1;
        i_req_valid = 1'b0;
        i_req_op    = '0;
        i_req_rd    = '0;
        i_req_rs1   = '0;
        i_req_rs2   = '0;
        tick();
        tick();
        i_Reset = 1'b0;
        chk("rst_ready", 32'(o_req_ready), 32'd1);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_result", 32'(o_result), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
`ifdef RFSEQ_FLAGS_EN
        chk("rst_flag_z", 32'(o_flag_z), 32'd0);
        chk("rst_flag_c", 32'(o_flag_c), 32'd0);
`endif

        load(4'd1, 16'h7FFF);
        load(4'd2, 16'h0001);
        load(4'd5, 16'h0001);
        load(4'd8, 16'hAAAA);
        load(4'd9, 16'h5555);
        load(4'd10, 16'hFFFF);
        load(4'd11, 16'hFFFF);
        load(4'd7, 16'h0001);
        load(4'd6, 16'h1234);

        // ADD overflowing into the sign bit
        issue(3'd0, 4'd3, 4'd1, 4'd2, 1'b0, 1'b0);
        waitDone();
        chk("add_r3", 32'(regs[3]), 32'h8000);

        // SUB from r0 borrows
        issue(3'd1, 4'd4, 4'd0, 4'd5, 1'b0, 1'b0);
        waitDone();
        chk("sub_r4", 32'(regs[4]), 32'hFFFF);

        // Back-to-back XORs with valid held; fields change while the first is busy
        issue(3'd4, 4'd12, 4'd8, 4'd9, 1'b1, 1'b0);
        issue(3'd4, 4'd13, 4'd10, 4'd11, 1'b0, 1'b1);
        waitDone();
        chk("xor_r12", 32'(regs[12]), 32'hFFFF);
        chk("xor_r13", 32'(regs[13]), 32'h0000);

        // SHR into r0
        issue(3'd7, 4'd0, 4'd7, 4'd0, 1'b0, 1'b0);
        waitDone();

        // Reset during RDB must abort without a write-back
        keep6 = regs[6];
        issue(3'd0, 4'd6, 4'd1, 4'd2, 1'b0, 1'b0);
        n = 0;
        while (!o_outputB && n < 10) begin
            tick();
            n++;
        end
        if (!o_outputB) timeoutFail("rdb_timeout");
        sb.delete();
        i_Reset = 1'b1;
        tick();
        i_Reset = 1'b0;
        chk("abort_ready", 32'(o_req_ready), 32'd1);
        chk("abort_result", 32'(o_result), 32'd0);
        for (int i = 0; i < 8; i++) tick();
        chk("abort_r6", 32'(regs[6]), 32'(keep6));

        // Random stream against the reference model
        for (int i = 1; i < 16; i++) load(4'(i), 16'($urandom));
        for (int i = 0; i < 1000; i++) begin
            issue(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, 1'b0);
            waitDone();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_sequencer.md
REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning register/bus word width.
REQ-002 SHALL have port i_Clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port i_Reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports i_req_valid  input  1  and o_req_ready  output  1  forming the request handshake.
REQ-005 SHALL have ports i_req_op  input  3  ALU opcode; i_req_rd, i_req_rs1, i_req_rs2  input  4 each  register indices.
REQ-006 SHALL have ports o_selectLatch, o_outputA, o_outputB, o_latchC  output  1 each  register file control strobes.
REQ-007 SHALL have ports o_bus_data  output  DATA_W  and o_bus_valid  output  1  driving the register file bus input.
REQ-008 SHALL have port i_rf_data  input  DATA_W  register file registered read data.
REQ-009 SHALL have ports o_result  output  DATA_W  last written value; o_done  output  1  completion pulse; o_busy  output  1  operation in flight.

Function
REQ-010 SHALL implement states IDLE, SEL, RDA, RDB, CAPB, WB, each occupying exactly one cycle except IDLE.
REQ-011 SHALL assert o_req_ready only in IDLE; request accepted when i_req_valid && o_req_ready at a rising edge, then IDLE->SEL.
REQ-012 SHALL capture op, rd, rs1, rs2 at acceptance; request input changes after acceptance have no effect.
REQ-013 SEL: o_selectLatch=1, o_bus_valid=1, o_bus_data={zero pad, rd, rs2, rs1} (rs1 in [3:0], rs2 [7:4], rd [11:8]); next RDA.
REQ-014 RDA: o_outputA=1, o_bus_valid=0; next RDB.
REQ-015 RDB: o_outputB=1; operand A <= i_rf_data at end of cycle; next CAPB.
REQ-016 CAPB: no strobes; operand B <= i_rf_data at end of cycle; next WB.
REQ-017 WB: o_latchC=1, o_bus_valid=1, o_bus_data=ALU(A,B) computed combinationally; o_result <= same value; next IDLE.
REQ-018 o_done SHALL be high exactly one cycle, the cycle after WB (first IDLE cycle); a new request may be accepted in that same cycle.
REQ-019 Opcodes: 000 A+B, 001 A-B, 010 A&B, 011 A|B, 100 A^B, 101 A, 110 A<<1, 111 A>>1 (logical); all results modulo 2^DATA_W.
REQ-020 At most one of the four control strobes SHALL be high in any cycle; o_bus_valid high only in SEL and WB.
REQ-021 o_busy SHALL equal (state != IDLE).
REQ-022 rd=0 SHALL still run full sequence including WB strobe (register file discards); latency fixed at 6 cycles acceptance-to-done.
REQ-023 o_bus_data SHALL be 0 in all states except SEL and WB.

Reset
REQ-024 On i_Reset high at a rising edge: state=IDLE, operands, captured fields, o_result=0, o_done=0; all strobes and o_bus_valid 0 in the following cycle.
REQ-025 Reset mid-operation SHALL abort without any o_latchC pulse; o_req_ready=1 the cycle after reset deasserts.

Configuration
REQ-026 Macro RFSEQ_FLAGS_EN SHALL, when defined, add outputs o_flag_z  output  1  and o_flag_c  output  1, registered in WB.
REQ-027 With RFSEQ_FLAGS_EN: z = (result==0); c = carry-out for ADD, borrow (A<B) for SUB, bit shifted out for SHL/SHR, 0 otherwise; both reset to 0; hold until next WB.
REQ-028 Without RFSEQ_FLAGS_EN: flag ports and flag logic SHALL not exist; all other behaviour identical.

Verification
REQ-029 ADD rd=3 rs1=1 rs2=2, r1=0x7FFF r2=0x0001 -> SEL bus 0x0321, WB bus 0x8000 with latchC, o_done 6 cycles after acceptance, o_result=0x8000.
REQ-030 SUB rd=4 rs1=0 rs2=5, r5=0x0001 -> write 0xFFFF; with RFSEQ_FLAGS_EN c=1 z=0.
REQ-031 Back-to-back: valid held high with two XOR requests (0xAAAA^0x5555, then 0xFFFF^0xFFFF) -> second accepted on done cycle, results 0xFFFF then 0x0000 (z=1 if flags enabled); ready low throughout busy.
REQ-032 Reset asserted during RDB -> no o_latchC ever asserted for that request, target register unchanged, o_result=0, ready=1 after reset.
REQ-033 SHR r7=0x0001 into rd=0 -> WB strobe issued with 0x0000, register file r0 reads 0; with flags c=1 z=1.
REQ-034 Strobe monitor over random op/index stream of 1000 requests -> never two strobes high in one cycle, every result matches reference model.
